i2c_target: RTL and testbench

- I2C responder (target) that answers the camera-side I2C initiator on the same two-wire bus.
- Used as a bench/board stand-in for the Pixart sensor at its 7-bit address, and as a generic register-mapped I2C target.
- Oversamples SCL/SDA on the system clock; drives SDA open-drain only.
- Exposes a simple byte-wide register port to a register file or application logic.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 49 ++++
 rtl/i2c_target.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-level constants, default Pixart address and target FSM state codes.
package i2c_pkg;

    localparam logic [6:0] PIXART_ADDR = 7'h58;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_WPTR      = 4'd3;
    localparam logic [3:0] ST_WPTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RACK      = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
        return ptr + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversampling front end: synchronises SCL/SDA and derives edge, START and STOP pulses
// from the synchronised level and a one-clock delayed copy.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_r;
    logic [STAGES-1:0] sda_sync_r;
    logic              scl_dly_r;
    logic              sda_dly_r;
    logic              scl_s;
    logic              sda_s;

    // Synchroniser chains and delay flops; idle bus level is high on both lines.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_r <= {STAGES{1'b1}};
            sda_sync_r <= {STAGES{1'b1}};
            scl_dly_r  <= 1'b1;
            sda_dly_r  <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[STAGES-2:0], sda_in};
            scl_dly_r  <= scl_s;
            sda_dly_r  <= sda_s;
        end
    end

    assign scl_s     = scl_sync_r[STAGES-1];
    assign sda_s     = sda_sync_r[STAGES-1];
    assign sda_lvl   = sda_s;
    assign scl_rise  = scl_s & ~scl_dly_r;
    assign scl_fall  = ~scl_s & scl_dly_r;
    assign start_det = scl_s & scl_dly_r & sda_dly_r & ~sda_s;
    assign stop_det  = scl_s & scl_dly_r & ~sda_dly_r & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: pointer write, auto-incrementing burst
// writes and reads, open-drain SDA only, never stretches SCL.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = PIXART_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic       sda_lvl_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_det_s;
    logic       stop_det_s;

    logic [3:0] state_r;
    logic [3:0] cnt_r;
    logic [7:0] shift_r;
    logic       rw_r;
    logic       sda_oe_r;
    logic [7:0] reg_addr_r;
    logic [7:0] reg_wdata_r;
    logic       reg_we_r;
    logic       busy_r;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_lvl   (sda_lvl_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    // Protocol FSM; ACK states drive SDA from the first SCL fall and release on the second.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            shift_r     <= 8'd0;
            rw_r        <= 1'b0;
            sda_oe_r    <= 1'b0;
            reg_addr_r  <= 8'd0;
            reg_wdata_r <= 8'd0;
            reg_we_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            reg_we_r <= 1'b0;
            if (stop_det_s) begin
                state_r  <= ST_IDLE;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
                cnt_r    <= 4'd0;
            end else if (start_det_s) begin
                state_r  <= ST_ADDR;
                sda_oe_r <= 1'b0;
                cnt_r    <= 4'd0;
            end else begin
                case (state_r)
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r <= {shift_r[6:0], sda_lvl_s};
                            cnt_r   <= cnt_r + 4'd1;
                            if (cnt_r == 4'd7) begin
                                cnt_r <= 4'd0;
                                rw_r  <= sda_lvl_s;
                                if (shift_r[6:0] == TARGET_ADDR) begin
                                    state_r <= ST_ADDR_ACK;
                                    busy_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!sda_oe_r) begin
                                sda_oe_r <= 1'b1;
                            end else if (rw_r) begin
                                state_r  <= ST_RDATA;
                                shift_r  <= reg_rdata;
                                sda_oe_r <= ~reg_rdata[7];
                                cnt_r    <= 4'd0;
                            end else begin
                                state_r  <= ST_WPTR;
                                sda_oe_r <= 1'b0;
                                cnt_r    <= 4'd0;
                            end
                        end
                    end
                    ST_WPTR, ST_WDATA: begin
                        if (scl_rise_s) begin
                            shift_r <= {shift_r[6:0], sda_lvl_s};
                            cnt_r   <= cnt_r + 4'd1;
                            if (cnt_r == 4'd7) begin
                                cnt_r <= 4'd0;
                                if (state_r == ST_WDATA) begin
                                    reg_wdata_r <= {shift_r[6:0], sda_lvl_s};
                                    reg_we_r    <= 1'b1;
                                    state_r     <= ST_WDATA_ACK;
                                end else begin
                                    state_r <= ST_WPTR_ACK;
                                end
                            end
                        end
                    end
                    ST_WPTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!sda_oe_r) begin
                                sda_oe_r <= 1'b1;
                                // Pointer advances only after the strobe has been seen at the old address.
                                if (state_r == ST_WDATA_ACK) begin
                                    reg_addr_r <= ptr_inc(reg_addr_r);
                                end
                            end else begin
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_WDATA;
                                cnt_r    <= 4'd0;
                                if (state_r == ST_WPTR_ACK) begin
                                    reg_addr_r <= shift_r;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise_s) begin
                            shift_r <= {shift_r[6:0], 1'b0};
                            cnt_r   <= cnt_r + 4'd1;
                        end else if (scl_fall_s) begin
                            if (cnt_r == 4'd8) begin
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_RACK;
                                cnt_r    <= 4'd0;
                            end else begin
                                sda_oe_r <= ~shift_r[7];
                            end
                        end
                    end
                    ST_RACK: begin
                        // Entered on a fall, so any fall seen here follows an ACKed rise.
                        if (scl_rise_s) begin
                            if (sda_lvl_s == ACK_BIT) begin
                                reg_addr_r <= ptr_inc(reg_addr_r);
                            end else begin
                                state_r <= ST_IGNORE;
                            end
                        end else if (scl_fall_s) begin
                            shift_r  <= reg_rdata;
                            sda_oe_r <= ~reg_rdata[7];
                            cnt_r    <= 4'd0;
                            state_r  <= ST_RDATA;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        sda_oe_r <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_we    = reg_we_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-level I2C initiator model, write/read scoreboards,
// register file modelled as reg_rdata = reg_addr ^ 8'hA5.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    int         oe_cnt   = 0;
    logic [15:0] we_q[$];
    logic [7:0]  rd_q[$];
    logic [15:0] we_e;
    logic [7:0]  ptr_m;

    always #5 clk = ~clk;

    assign sda_in    = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'hA5;

    i2c_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-strobe scoreboard and SDA-drive activity counter.
    always @(negedge clk) begin
        if (reset && reg_we) begin
            if (we_q.size() == 0) begin
                chk("we_unexpected", we_q.size(), 32'd1);
            end else begin
                we_e = we_q.pop_front();
                chk("we_addr", reg_addr, we_e[15:8]);
                chk("we_data", reg_wdata, we_e[7:0]);
            end
        end
        if (sda_oe) oe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_in;   wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        logic a;
        write_byte(b, a);
        chk(tag, a, ACK_BIT);
    endtask

    task automatic send_ptr(input logic [7:0] p);
        send(p, "ptr_ack");
        ptr_m = p;
    endtask

    task automatic wr_data(input logic [7:0] b);
        we_q.push_back({ptr_m, b});
        ptr_m = ptr_m + 8'd1;
        send(b, "wdata_ack");
    endtask

    task automatic rd_data(input logic mack);
        logic [7:0] d;
        logic       bit_v;
        rd_q.push_back(ptr_m ^ 8'hA5);
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            d[i] = bit_v;
        end
        write_bit(mack);
        if (mack == ACK_BIT) ptr_m = ptr_m + 8'd1;
        chk("rdata", d, rd_q.pop_front());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic found;
        int   oe0;
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        ptr_m = 8'h00;
        wait_clk(5);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_reg_we", reg_we, 1'b0);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        wait_clk(4);

        // Burst write of two bytes at 0x30.
        bus_start();
        send(8'hB0, "addr_w_ack");
        chk("busy_on", busy, 1'b1);
        send_ptr(8'h30);
        wr_data(8'h01);
        wr_data(8'h08);
        bus_stop();
        wait_clk(4);
        chk("busy_off", busy, 1'b0);
        chk("we_drain1", we_q.size(), 32'd0);

        // Pointer write, repeated START, three-byte read.
        bus_start();
        send(8'hB0, "addr_w_ack");
        send_ptr(8'h36);
        bus_start();
        send(8'hB1, "addr_r_ack");
        rd_data(ACK_BIT);
        rd_data(ACK_BIT);
        rd_data(NACK_BIT);
        chk("oe_after_nack", sda_oe, 1'b0);
        bus_stop();
        wait_clk(4);

        // Foreign address: no ACK, no drive, no writes.
        oe0 = oe_cnt;
        bus_start();
        write_byte(8'hA0, a);
        chk("foreign_nack", a, NACK_BIT);
        chk("foreign_busy", busy, 1'b0);
        write_byte(8'h12, a);
        chk("foreign_no_drive", oe_cnt - oe0, 32'd0);
        bus_stop();
        wait_clk(4);

        // Pointer wrap 0xFF -> 0x00.
        bus_start();
        send(8'hB0, "addr_w_ack");
        send_ptr(8'hFE);
        wr_data(8'h11);
        wr_data(8'h22);
        wr_data(8'h33);
        bus_stop();
        wait_clk(4);
        chk("we_drain_wrap", we_q.size(), 32'd0);

        // STOP mid data byte, then a normal addressed write.
        bus_start();
        send(8'hB0, "addr_w_ack");
        send_ptr(8'h50);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        bus_stop();
        wait_clk(4);
        chk("midstop_oe", sda_oe, 1'b0);
        chk("midstop_busy", busy, 1'b0);
        bus_start();
        send(8'hB0, "after_stop_ack");
        bus_stop();
        wait_clk(4);

        // Reset while driving a 0 data bit (0x80 ^ 0xA5 = 0x25, MSB 0).
        bus_start();
        send(8'hB0, "addr_w_ack");
        send_ptr(8'h80);
        bus_start();
        send(8'hB1, "addr_r_ack");
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (sda_oe) found = 1'b1;
            else wait_clk(1);
        end
        chk("rd_drive_low", found, 1'b1);
        reset = 1'b0;
        wait_clk(1);
        chk("rst_mid_oe", sda_oe, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_addr", reg_addr, 8'h00);
        wait_clk(3);
        reset = 1'b1;
        ptr_m = 8'h00;
        oe0 = oe_cnt;
        read_bit(a);
        read_bit(a);
        chk("hold_no_drive", oe_cnt - oe0, 32'd0);
        chk("hold_addr", reg_addr, ptr_m);
        chk("hold_busy", busy, 1'b0);
        bus_stop();
        wait_clk(4);
        chk("we_drain_end", we_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
